// File: rtl/bin2pos_acc_pkg.sv
// Shared types and default widths for the bin2pos_acc accumulator.
package bin2pos_acc_pkg;

  localparam int DEF_BIN_WIDTH = 4;
  localparam int DEF_POS_WIDTH = 2 ** DEF_BIN_WIDTH;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/bin2pos.sv
// Combinational binary-to-one-hot decoder; indices >= POS_WIDTH decode to all zeros.
module bin2pos #(
  parameter int BIN_WIDTH = 4,
  parameter int POS_WIDTH = 2 ** BIN_WIDTH
) (
  input  logic [BIN_WIDTH-1:0] s_bin,
  output logic [POS_WIDTH-1:0] onehot
);

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < POS_WIDTH; i++) begin
      onehot[i] = (s_bin == BIN_WIDTH'(i));
    end
  end

endmodule

// File: rtl/bin2pos_acc.sv
// Accumulates binary indices into a registered multi-hot mask with count, full and error flags.
// Define BIN2POS_ACC_FIRST_EN to build the registered lowest-set-bit encoder (first_bin/first_vld).
module bin2pos_acc
  import bin2pos_acc_pkg::*;
#(
  parameter int BIN_WIDTH = DEF_BIN_WIDTH,
  parameter int POS_WIDTH = 2 ** BIN_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [BIN_WIDTH-1:0]           s_bin,
  input  logic                           clr,
  output logic [POS_WIDTH-1:0]           pos,
  output logic [$clog2(POS_WIDTH+1)-1:0] cnt,
  output logic                           full,
  output logic                           err_dup,
  output logic                           err_range,
  output logic                           err_sticky,
  output logic [BIN_WIDTH-1:0]           first_bin,
  output logic                           first_vld
);

  localparam int CW = $clog2(POS_WIDTH + 1);

  state_t                 state, state_nxt;
  logic [POS_WIDTH-1:0]   set_mask, base_pos, pos_nxt;
  logic [CW-1:0]          base_cnt, cnt_nxt;
  logic                   accept, in_range, dup, set, range_err, sticky_nxt;

  bin2pos #(
    .BIN_WIDTH (BIN_WIDTH),
    .POS_WIDTH (POS_WIDTH)
  ) u_bin2pos (
    .s_bin  (s_bin),
    .onehot (set_mask)
  );

  // A clear frees the whole mask this cycle, so a FULL accumulator can take the index that rides with it.
  assign s_ready  = (state != FULL) || clr;
  assign accept   = s_valid && s_ready;
  assign in_range = |set_mask;
  assign full     = (state == FULL);

  always_comb begin
    base_pos   = clr ? '0 : pos;
    base_cnt   = clr ? '0 : cnt;
    dup        = accept && in_range && |(set_mask & base_pos);
    range_err  = accept && !in_range;
    set        = accept && in_range && !dup;
    pos_nxt    = base_pos | (set ? set_mask : '0);
    cnt_nxt    = base_cnt + {{(CW-1){1'b0}}, set};
    sticky_nxt = (clr ? 1'b0 : err_sticky) | dup | range_err;

    state_nxt = state;
    if (clr) state_nxt = EMPTY;
    if (set) state_nxt = (cnt_nxt == CW'(POS_WIDTH)) ? FULL : PARTIAL;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      pos        <= '0;
      cnt        <= '0;
      err_dup    <= 1'b0;
      err_range  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_nxt;
      pos        <= pos_nxt;
      cnt        <= cnt_nxt;
      err_dup    <= dup;
      err_range  <= range_err;
      err_sticky <= sticky_nxt;
    end
  end

`ifdef BIN2POS_ACC_FIRST_EN
  logic [BIN_WIDTH-1:0] first_nxt;

  // Encoded from pos_nxt so the registered result lines up with the registered mask.
  always_comb begin
    first_nxt = '0;
    for (int i = POS_WIDTH - 1; i >= 0; i--) begin
      if (pos_nxt[i]) first_nxt = BIN_WIDTH'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_bin <= '0;
      first_vld <= 1'b0;
    end else begin
      first_bin <= first_nxt;
      first_vld <= |pos_nxt;
    end
  end
`else
  assign first_bin = '0;
  assign first_vld = 1'b0;
`endif

endmodule

// File: tb/tb_bin2pos_acc.sv
// Directed self-checking bench: an 8-wide and a 6-wide accumulator, both with BIN_WIDTH=3.
module tb_bin2pos_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, clr;
  logic [2:0] s_bin;
  logic       s_ready;
  logic [7:0] pos;
  logic [3:0] cnt;
  logic       full, err_dup, err_range, err_sticky, first_vld;
  logic [2:0] first_bin;

  logic       s_valid6, clr6;
  logic [2:0] s_bin6;
  logic       s_ready6;
  logic [5:0] pos6;
  logic [2:0] cnt6;
  logic       full6, err_dup6, err_range6, err_sticky6, first_vld6;
  logic [2:0] first_bin6;

  int n_checks = 0;
  int n_errors = 0;

`ifdef BIN2POS_ACC_FIRST_EN
  localparam bit FIRST_ON = 1'b1;
`else
  localparam bit FIRST_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  bin2pos_acc #(.BIN_WIDTH(3), .POS_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_bin(s_bin), .clr(clr),
    .pos(pos), .cnt(cnt), .full(full), .err_dup(err_dup), .err_range(err_range),
    .err_sticky(err_sticky), .first_bin(first_bin), .first_vld(first_vld)
  );

  bin2pos_acc #(.BIN_WIDTH(3), .POS_WIDTH(6)) dut6 (
    .clk(clk), .rst(rst), .s_valid(s_valid6), .s_ready(s_ready6), .s_bin(s_bin6), .clr(clr6),
    .pos(pos6), .cnt(cnt6), .full(full6), .err_dup(err_dup6), .err_range(err_range6),
    .err_sticky(err_sticky6), .first_bin(first_bin6), .first_vld(first_vld6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] b);
    s_valid = 1'b1;
    s_bin   = b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic write6(input logic [2:0] b);
    s_valid6 = 1'b1;
    s_bin6   = b;
    tick();
    s_valid6 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; clr = 1'b0; s_bin = '0;
    s_valid6 = 1'b0; clr6 = 1'b0; s_bin6 = '0;
    repeat (2) tick();

    check("rst_pos",        pos,        8'h00);
    check("rst_cnt",        cnt,        4'd0);
    check("rst_full",       full,       1'b0);
    check("rst_err_dup",    err_dup,    1'b0);
    check("rst_err_range",  err_range,  1'b0);
    check("rst_err_sticky", err_sticky, 1'b0);
    check("rst_first_bin",  first_bin,  3'd0);
    check("rst_first_vld",  first_vld,  1'b0);
    check("rst_pos6",       pos6,       6'h00);
    rst = 1'b0;
    #1;
    check("rst_s_ready",    s_ready,    1'b1);

    // Write 2 then 5.
    write(3'd2);
    check("w2_pos",         pos,        8'h04);
    check("w2_cnt",         cnt,        4'd1);
    write(3'd5);
    check("w5_pos",         pos,        8'b0010_0100);
    check("w5_cnt",         cnt,        4'd2);
    check("w5_first_bin",   first_bin,  FIRST_ON ? 3'd2 : 3'd0);
    check("w5_first_vld",   first_vld,  FIRST_ON ? 1'b1 : 1'b0);
    check("w5_no_dup",      err_dup,    1'b0);

    // Duplicate 5.
    write(3'd5);
    check("dup_pos",        pos,        8'b0010_0100);
    check("dup_cnt",        cnt,        4'd2);
    check("dup_pulse",      err_dup,    1'b1);
    check("dup_sticky",     err_sticky, 1'b1);
    tick();
    check("dup_pulse_end",  err_dup,    1'b0);
    check("dup_sticky_hold", err_sticky, 1'b1);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_pos",        pos,        8'h00);
    check("clr_cnt",        cnt,        4'd0);
    check("clr_sticky",     err_sticky, 1'b0);

    // Fill 0..7.
    for (int i = 0; i < 8; i++) write(3'(i));
    check("fill_pos",       pos,        8'hFF);
    check("fill_cnt",       cnt,        4'd8);
    check("fill_full",      full,       1'b1);
    check("fill_s_ready",   s_ready,    1'b0);

    s_valid = 1'b1; s_bin = 3'd3;
    tick();
    tick();
    s_valid = 1'b0;
    check("full_hold_pos",  pos,        8'hFF);
    check("full_hold_cnt",  cnt,        4'd8);
    check("full_hold_dup",  err_dup,    1'b0);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("fclr_pos",       pos,        8'h00);
    check("fclr_s_ready",   s_ready,    1'b1);
    check("fclr_full",      full,       1'b0);

    // Clear plus transfer of 4 while full.
    for (int i = 0; i < 8; i++) write(3'(i));
    check("refill_pos",     pos,        8'hFF);
    clr = 1'b1; s_valid = 1'b1; s_bin = 3'd4;
    #1;
    check("clrx_s_ready",   s_ready,    1'b1);
    tick();
    clr = 1'b0; s_valid = 1'b0;
    check("clrx_pos",       pos,        8'b0001_0000);
    check("clrx_cnt",       cnt,        4'd1);
    check("clrx_no_dup",    err_dup,    1'b0);
    check("clrx_full",      full,       1'b0);
    check("clrx_first_bin", first_bin,  FIRST_ON ? 3'd4 : 3'd0);

    // Six-wide instance: out-of-range indices.
    write6(3'd7);
    check("r7_pulse",       err_range6, 1'b1);
    check("r7_pos",         pos6,       6'h00);
    check("r7_cnt",         cnt6,       3'd0);
    check("r7_sticky",      err_sticky6, 1'b1);
    tick();
    check("r7_pulse_end",   err_range6, 1'b0);
    write6(3'd6);
    check("r6_pulse",       err_range6, 1'b1);
    check("r6_pos",         pos6,       6'h00);
    write6(3'd5);
    check("w5_6_pos",       pos6,       6'b10_0000);
    check("w5_6_cnt",       cnt6,       3'd1);
    check("w5_6_range",     err_range6, 1'b0);

    // Asynchronous reset between edges with pos=8'h0F.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) write(3'(i));
    check("pre_arst_pos",   pos,        8'h0F);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pos",       pos,        8'h00);
    check("arst_cnt",       cnt,        4'd0);
    check("arst_pos6",      pos6,       6'h00);
    rst = 1'b0;
    tick();
    check("arst_s_ready",   s_ready,    1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
